com_bridge_n: RTL and testbench

- Parametrised host-to-FPGA register bridge over one UART link.
- Carries NCHAN host-writable registers and NCHAN FPGA-observed registers, each DATA_W bits wide, using an ASCII-hex protocol.
- Sends a "D" report automatically when any observed register changes.
- Accepts an explicit read command from the host and answers with an "R" report.
- Sits between the top-level RX/TX pins and user logic; instantiates uart_rx and uart_tx internally.

---
 rtl/com_bridge_n.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_com_bridge_n.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/com_bridge_n.sv
`default_nettype none
// ------------------------------------------------------------------------
// com_bridge_n: ASCII-hex UART bridge for NCHAN host-written/FPGA-read regs
// Rev 1.0
// ------------------------------------------------------------------------

module uart_rx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rx,
  output logic [7:0] data,
  output logic       ready
);
  localparam int CLKS  = CLK_FREQ / BAUD;
  localparam int HALF  = CLKS / 2;
  localparam int CNT_W = $clog2(CLKS);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;

  rstate_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       nbit;
  logic [7:0]       sh;
  // Synchroniser holds the inverted line so an all-zero power-up reads as idle.
  logic [1:0]       syncn;
  logic             rxs;

  assign rxs = ~syncn[1];

  always_ff @(posedge clk) begin
    syncn <= {syncn[0], ~rx};
    ready <= 1'b0;
    case (state)
      R_IDLE: if (!rxs) begin
        cnt   <= '0;
        state <= R_START;
      end
      R_START: if (cnt == CNT_W'(HALF - 1)) begin
        cnt   <= '0;
        nbit  <= '0;
        state <= rxs ? R_IDLE : R_DATA;
      end else cnt <= cnt + 1'b1;
      R_DATA: if (cnt == CNT_W'(CLKS - 1)) begin
        cnt <= '0;
        sh  <= {rxs, sh[7:1]};
        if (nbit == 3'd7) state <= R_STOP;
        else nbit <= nbit + 3'd1;
      end else cnt <= cnt + 1'b1;
      R_STOP: if (cnt == CNT_W'(CLKS - 1)) begin
        state <= R_IDLE;
        if (rxs) begin
          data  <= sh;
          ready <= 1'b1;
        end
      end else cnt <= cnt + 1'b1;
      default: state <= R_IDLE;
    endcase
  end
endmodule

module uart_tx #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);
  localparam int CLKS  = CLK_FREQ / BAUD;
  localparam int CNT_W = $clog2(CLKS);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       nbit;
  // Shift register kept inverted so the all-zero power-up state drives a high line.
  logic [9:0]       shn;

  always_ff @(posedge clk) begin
    if (!busy) begin
      if (start) begin
        shn  <= ~{1'b1, data, 1'b0};
        busy <= 1'b1;
        cnt  <= '0;
        nbit <= '0;
      end
    end else if (cnt == CNT_W'(CLKS - 1)) begin
      cnt <= '0;
      shn <= {1'b0, shn[9:1]};
      if (nbit == 4'd9) busy <= 1'b0;
      else nbit <= nbit + 4'd1;
    end else cnt <= cnt + 1'b1;
  end

  assign tx = ~shn[0];
endmodule

module com_bridge_n #(
  parameter int CLK_FREQ = 12_000_000,
  parameter int BAUD     = 115200,
  parameter int NCHAN    = 2,
  parameter int DATA_W   = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    RX,
  output logic                    TX,
  output logic [NCHAN*DATA_W-1:0] DATA_IN,
  output logic [NCHAN-1:0]        IN_STROBE,
  input  logic [NCHAN*DATA_W-1:0] DATA_OUT
);
  localparam int NDIG  = DATA_W / 4;
  localparam int DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (NCHAN < 1 || NCHAN > 16 || DATA_W < 4 || DATA_W > 32 || (DATA_W % 4) != 0) begin : g_bad_params
    $error("com_bridge_n: NCHAN must be 1..16 and DATA_W a multiple of 4 in 4..32");
  end

  function automatic logic [4:0] hex_val(input logic [7:0] b);
    logic [7:0] t;
    t = 8'h00;
    if (b >= "0" && b <= "9") begin t = b - 8'h30; return {1'b1, t[3:0]}; end
    if (b >= "A" && b <= "F") begin t = b - 8'h37; return {1'b1, t[3:0]}; end
    if (b >= "a" && b <= "f") begin t = b - 8'h57; return {1'b1, t[3:0]}; end
    return 5'b0;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_rx (
    .clk(CLK), .rx(RX), .data(rx_data), .ready(rx_ready)
  );
  uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_tx (
    .clk(CLK), .start(tx_start), .data(tx_data), .busy(tx_busy), .tx(TX)
  );

  typedef enum logic [1:0] {P_IDLE, P_CH, P_DIG} pstate_t;
  typedef enum logic [2:0] {T_IDLE, T_HDR, T_CH, T_DIG, T_EOL} tstate_t;

  pstate_t           pstate;
  logic              is_read;
  logic [3:0]        pch;
  logic [DATA_W-1:0] acc;
  logic [DIG_W-1:0]  pdig;
  logic              rd_pend;
  logic [3:0]        rd_ch;
  logic              rd_take;

  logic [4:0]        hv;
  logic              ch_ok;
  logic [DATA_W+3:0] acc_wide;
  logic [DATA_W-1:0] acc_next;

  tstate_t           tstate;
  logic [7:0]        hdr;
  logic [3:0]        tch;
  logic [DATA_W-1:0] tdat;
  logic [DIG_W-1:0]  tdig;
  logic [DATA_W-1:0] shadow [NCHAN];
  logic [3:0]        ptr;
  logic [NCHAN-1:0]  dirty;
  logic              found;
  logic [3:0]        sel;
  logic [DATA_W-1:0] sel_val;
  logic [DATA_W-1:0] rd_val;
  logic [7:0]        cur_byte;

  always_comb begin
    hv       = hex_val(rx_data);
    ch_ok    = {1'b0, hv[3:0]} < 5'(NCHAN);
    acc_wide = {acc, hv[3:0]};
    acc_next = acc_wide[DATA_W-1:0];
  end

  assign rd_take = (tstate == T_IDLE) && rd_pend;

  always_ff @(posedge CLK) begin
    if (RST) begin
      DATA_IN   <= '0;
      IN_STROBE <= '0;
      pstate    <= P_IDLE;
      is_read   <= 1'b0;
      pch       <= '0;
      acc       <= '0;
      pdig      <= '0;
      rd_pend   <= 1'b0;
      rd_ch     <= '0;
    end else begin
      IN_STROBE <= '0;
      if (rd_take) rd_pend <= 1'b0;
      if (rx_ready) begin
        if (rx_data == "S" || rx_data == "R") begin
          pstate  <= P_CH;
          is_read <= (rx_data == "R");
        end else begin
          case (pstate)
            P_CH: begin
              if (!hv[4]) pstate <= P_IDLE;
              else if (is_read) begin
                pstate <= P_IDLE;
                // A newer read simply replaces one still waiting for service.
                if (ch_ok) begin
                  rd_pend <= 1'b1;
                  rd_ch   <= hv[3:0];
                end
              end else begin
                pch    <= hv[3:0];
                pdig   <= '0;
                acc    <= '0;
                pstate <= P_DIG;
              end
            end
            P_DIG: begin
              if (!hv[4]) pstate <= P_IDLE;
              else begin
                acc <= acc_next;
                if (pdig == DIG_W'(NDIG - 1)) begin
                  pstate <= P_IDLE;
                  for (int k = 0; k < NCHAN; k++) begin
                    if (pch == 4'(k)) begin
                      DATA_IN[k*DATA_W +: DATA_W] <= acc_next;
                      IN_STROBE[k]                <= 1'b1;
                    end
                  end
                end else pdig <= pdig + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    sel     = '0;
    sel_val = '0;
    rd_val  = '0;
    for (int k = 0; k < NCHAN; k++)
      dirty[k] = DATA_OUT[k*DATA_W +: DATA_W] != shadow[k];
    // Round-robin: first dirty channel at or after ptr.
    for (int i = 0; i < NCHAN; i++) begin
      idx = (int'(ptr) + i) % NCHAN;
      if (!found && dirty[idx]) begin
        found = 1'b1;
        sel   = 4'(idx);
      end
    end
    for (int k = 0; k < NCHAN; k++) begin
      if (sel == 4'(k))   sel_val = DATA_OUT[k*DATA_W +: DATA_W];
      if (rd_ch == 4'(k)) rd_val  = DATA_OUT[k*DATA_W +: DATA_W];
    end
    case (tstate)
      T_HDR:   cur_byte = hdr;
      T_CH:    cur_byte = hex_char(tch);
      T_DIG:   cur_byte = hex_char(tdat[DATA_W-1 -: 4]);
      default: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tstate   <= T_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      hdr      <= '0;
      tch      <= '0;
      tdat     <= '0;
      tdig     <= '0;
      ptr      <= '0;
      for (int k = 0; k < NCHAN; k++) shadow[k] <= '0;
    end else begin
      case (tstate)
        T_IDLE: begin
          if (rd_pend) begin
            hdr    <= "R";
            tch    <= rd_ch;
            tdat   <= rd_val;
            tstate <= T_HDR;
          end else if (found) begin
            hdr    <= "D";
            tch    <= sel;
            tdat   <= sel_val;
            for (int k = 0; k < NCHAN; k++)
              if (sel == 4'(k)) shadow[k] <= sel_val;
            ptr    <= (sel == 4'(NCHAN - 1)) ? 4'd0 : sel + 4'd1;
            tstate <= T_HDR;
          end
        end
        default: begin
          if (!tx_busy && !tx_start) begin
            tx_data  <= cur_byte;
            tx_start <= 1'b1;
          end else if (tx_busy && tx_start) begin
            tx_start <= 1'b0;
            case (tstate)
              T_HDR: tstate <= T_CH;
              T_CH: begin
                tdig   <= '0;
                tstate <= T_DIG;
              end
              T_DIG: begin
                tdat <= tdat << 4;
                if (tdig == DIG_W'(NDIG - 1)) tstate <= T_EOL;
                else tdig <= tdig + 1'b1;
              end
              default: tstate <= T_IDLE;
            endcase
          end
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_com_bridge_n.sv
`default_nettype none
// Directed bench for com_bridge_n: write vectors from a table, report/read sequences by hand.

module tb_com_bridge_n;
  typedef struct {
    string       cmd;
    logic [63:0] exp_data;
    logic [3:0]  exp_mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic        tx;
  logic [63:0] data_in;
  logic [3:0]  in_strobe;
  logic [63:0] data_out = '0;

  int vectors = 0;
  int errors  = 0;

  byte unsigned rxq[$];
  int           strobe_cycles = 0;
  logic [3:0]   strobe_mask   = '0;
  logic [63:0]  strobe_data   = '0;

  always #5 clk = ~clk;

  com_bridge_n #(
    .CLK_FREQ(1_152_000), .BAUD(115200), .NCHAN(4), .DATA_W(16)
  ) dut (
    .CLK(clk), .RST(rst), .RX(rx), .TX(tx),
    .DATA_IN(data_in), .IN_STROBE(in_strobe), .DATA_OUT(data_out)
  );

  // Bench-side UART receiver, 10 clocks per bit, sampling mid-bit.
  initial begin : mon_tx
    byte unsigned b;
    b = 8'h00;
    forever begin
      @(negedge tx);
      repeat (5) @(posedge clk);
      if (tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(posedge clk);
          b[i] = tx;
        end
        repeat (10) @(posedge clk);
        rxq.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    if (|in_strobe) begin
      strobe_cycles = strobe_cycles + 1;
      strobe_mask   = strobe_mask | in_strobe;
      strobe_data   = data_in;
    end
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 90000 cycles without finishing");
    $fatal(1, "watchdog expired");
  end

  function automatic string pc(byte unsigned b);
    string s;
    if (b == 8'h0A) s = "~";
    else s = $sformatf("%c", b);
    return s;
  endfunction

  task automatic send_byte(input byte unsigned b);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) @(negedge clk);
    end
    rx = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_frame(input string exp, input string name);
    int    cyc;
    string got;
    string want;
    bit    bad;
    cyc  = 0;
    got  = "";
    want = "";
    bad  = 1'b0;
    while (rxq.size() < exp.len() && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < exp.len(); i++) want = {want, pc(exp[i])};
    vectors++;
    if (rxq.size() < exp.len()) begin
      errors++;
      $display("FAIL %s: timeout with %0d bytes, required \"%s\"", name, rxq.size(), want);
      rxq.delete();
    end else begin
      for (int i = 0; i < exp.len(); i++) begin
        byte unsigned b;
        b   = rxq.pop_front();
        got = {got, pc(b)};
        if (b != exp[i]) bad = 1'b1;
      end
      if (bad) begin
        errors++;
        $display("FAIL %s: got \"%s\", required \"%s\"", name, got, want);
      end
    end
  endtask

  task automatic expect_quiet(input int cycles, input string name);
    repeat (cycles) @(negedge clk);
    vectors++;
    if (rxq.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d unexpected TX bytes, required 0", name, rxq.size());
      rxq.delete();
    end
  endtask

  task automatic apply_vec(input vec_t v);
    strobe_cycles = 0;
    strobe_mask   = '0;
    strobe_data   = '0;
    send_str(v.cmd);
    repeat (30) @(negedge clk);
    vectors++;
    if (data_in !== v.exp_data) begin
      errors++;
      $display("FAIL %s data_in: got %h, required %h", v.cmd, data_in, v.exp_data);
    end
    vectors++;
    if (strobe_mask !== v.exp_mask || strobe_cycles != ((v.exp_mask != 4'b0) ? 1 : 0)) begin
      errors++;
      $display("FAIL %s strobe: got mask %b over %0d cycles, required mask %b", v.cmd,
               strobe_mask, strobe_cycles, v.exp_mask);
    end
    if (v.exp_mask != 4'b0) begin
      vectors++;
      if (strobe_data !== v.exp_data) begin
        errors++;
        $display("FAIL %s strobe_data: got %h, required %h", v.cmd, strobe_data, v.exp_data);
      end
    end
  endtask

  initial begin : main
    vec_t vtab[11];
    vtab[0]  = '{"S2BEEF",    64'h0000_BEEF_0000_0000, 4'b0100};
    vtab[1]  = '{"S112x",     64'h0000_BEEF_0000_0000, 4'b0000};
    vtab[2]  = '{"S3a0b1",    64'hA0B1_BEEF_0000_0000, 4'b1000};
    vtab[3]  = '{"S51234",    64'hA0B1_BEEF_0000_0000, 4'b0000};
    vtab[4]  = '{"s1FFFF",    64'hA0B1_BEEF_0000_0000, 4'b0000};
    vtab[5]  = '{"S1ffff",    64'hA0B1_BEEF_FFFF_0000, 4'b0010};
    vtab[6]  = '{"SG1234",    64'hA0B1_BEEF_FFFF_0000, 4'b0000};
    vtab[7]  = '{"S01S0ABCD", 64'hA0B1_BEEF_FFFF_ABCD, 4'b0001};
    vtab[8]  = '{"S20001",    64'hA0B1_0001_FFFF_ABCD, 4'b0100};
    vtab[9]  = '{"S3123",     64'hA0B1_0001_FFFF_ABCD, 4'b0000};
    vtab[10] = '{"S3FFFF",    64'hFFFF_0001_FFFF_ABCD, 4'b1000};

    data_out = {16'h0000, 16'h00C5, 16'h0000, 16'h0000};
    rst = 1'b1;
    repeat (10) @(negedge clk);
    vectors++;
    if (data_in !== 64'h0) begin
      errors++;
      $display("FAIL reset data_in: got %h, required 0", data_in);
    end
    vectors++;
    if (in_strobe !== 4'h0) begin
      errors++;
      $display("FAIL reset in_strobe: got %b, required 0", in_strobe);
    end
    vectors++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL reset tx: got %b, required 1", tx);
    end
    rst = 1'b0;

    expect_frame("D200C5\n", "reset_report");
    expect_quiet(1500, "static_quiet");

    for (int i = 0; i < 11; i++) apply_vec(vtab[i]);
    expect_quiet(10, "writes_no_tx");

    // Pointer moves to 1 after this report, so ch1 precedes ch3 below.
    data_out[15:0] = 16'h0A0A;
    expect_frame("D00A0A\n", "ch0_report");
    data_out[31:16] = 16'h1111;
    data_out[63:48] = 16'h3333;
    repeat (150) @(negedge clk);
    data_out[31:16] = 16'h1234;
    repeat (100) @(negedge clk);
    data_out[31:16] = 16'h2222;
    expect_frame("D11111\n", "rr_first");
    expect_frame("D33333\n", "rr_second");
    expect_frame("D12222\n", "latest_only");
    expect_quiet(1500, "rr_quiet");

    data_out[47:32] = 16'h7777;
    repeat (50) @(negedge clk);
    send_str("R3");
    expect_frame("D27777\n", "frame_before_read");
    expect_frame("R33333\n", "deferred_read");
    expect_quiet(1500, "read_no_d");
    send_str("R9");
    expect_quiet(800, "bad_read_ignored");
    send_str("R0");
    expect_frame("R00A0A\n", "read_ch0");

    data_out[15:0] = 16'h5555;
    send_str("S01");
    rst = 1'b1;
    data_out = '0;
    rxq.delete();
    repeat (4) @(negedge clk);
    vectors++;
    if (data_in !== 64'h0) begin
      errors++;
      $display("FAIL midreset data_in: got %h, required 0", data_in);
    end
    vectors++;
    if (in_strobe !== 4'h0) begin
      errors++;
      $display("FAIL midreset in_strobe: got %b, required 0", in_strobe);
    end
    rst = 1'b0;
    send_str("234");
    repeat (1500) @(negedge clk);
    vectors++;
    if (rxq.size() > 1 || tx !== 1'b1) begin
      errors++;
      $display("FAIL tx_after_reset: got %0d bytes tx=%b, required at most 1 byte and tx=1",
               rxq.size(), tx);
    end
    rxq.delete();
    apply_vec('{"S50000", 64'h0, 4'b0000});
    apply_vec('{"S00042", 64'h0000_0000_0000_0042, 4'b0001});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
